pipe_stage_reg: RTL

Parametrised pipeline-stage register for the MIPS datapath. It replaces the fixed 32-bit enable register between IF/ID/EX/MEM/WB.
- Adds a valid/ready handshake, an optional 1-entry skid buffer for full throughput under back-pressure, a synchronous flush for branch/jump squash, and a saturating stall counter for performance monitoring.
- Sits between two pipeline stages; one instance per stage boundary, with WIDTH set to the stage bundle size.

---
 rtl/pipe_stage_reg.sv | 117 +++++++++++
 1 files changed

// File: rtl/pipe_stage_reg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// pipe_stage_reg : valid/ready pipeline-stage register with optional skid entry,
//                  synchronous flush and saturating back-pressure counter.
// Revision       : 1.0
// ============================================================================
module pipe_stage_reg #(
  parameter int              WIDTH       = 32,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0,
  parameter int              SKID        = 1,
  parameter int              CNT_W       = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [WIDTH-1:0] in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             en,
  input  logic             flush,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] stall_count
);

  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             main_valid_q, main_valid_d;
  logic             skid_full_q, skid_full_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic             in_ready_w;
  logic             accept;
  logic             consume;

  generate
    if (SKID != 0) begin : g_skid
      // Registered ready: tracks the next-state skid occupancy so it drops
      // the cycle after the skid entry fills.
      logic in_ready_q;
      always_ff @(posedge Clk) begin
        if (Reset) in_ready_q <= 1'b1;
        else       in_ready_q <= ~skid_full_d;
      end
      assign in_ready_w = in_ready_q;
    end else begin : g_noskid
      assign in_ready_w = ~main_valid_q | out_ready;
    end
  endgenerate

  always_comb begin
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    main_valid_d = main_valid_q;
    skid_full_d  = skid_full_q;
    stall_d      = stall_q;
    accept       = en & in_valid & in_ready_w;
    consume      = en & main_valid_q & out_ready;

    if (flush) begin
      main_valid_d = 1'b0;
      skid_full_d  = 1'b0;
    end else if (SKID != 0) begin
      if (!main_valid_q) begin
        if (accept) begin
          main_data_d  = in;
          main_valid_d = 1'b1;
        end
      end else if (!skid_full_q) begin
        if (accept && consume) begin
          main_data_d = in;
        end else if (accept) begin
          skid_data_d = in;
          skid_full_d = 1'b1;
        end else if (consume) begin
          main_valid_d = 1'b0;
        end
      end else if (consume) begin
        main_data_d = skid_data_q;
        skid_full_d = 1'b0;
      end
    end else begin
      if (accept) begin
        main_data_d  = in;
        main_valid_d = 1'b1;
      end else if (consume) begin
        main_valid_d = 1'b0;
      end
    end

    if (en && main_valid_q && !out_ready && !flush && (stall_q != {CNT_W{1'b1}}))
      stall_d = stall_q + CNT_W'(1);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      main_data_q  <= RESET_VALUE;
      skid_data_q  <= RESET_VALUE;
      main_valid_q <= 1'b0;
      skid_full_q  <= 1'b0;
      stall_q      <= '0;
    end else begin
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
      main_valid_q <= main_valid_d;
      skid_full_q  <= skid_full_d;
      stall_q      <= stall_d;
    end
  end

  assign in_ready    = in_ready_w;
  assign out         = main_data_q;
  assign out_valid   = main_valid_q;
  assign stall_count = stall_q;

endmodule
`default_nettype wire
